seqmul_frac: RTL and testbench

- Sequential fractional multiplier; the inverse datapath of the team's sequential fractional divider.
- Takes an 8-bit binary fraction Q (value Q/256) and a 19-bit scale, and reconstructs product = Q*scale/256 using shift-add, one fraction bit per clock.
- Sits beside the divider so ratios it produced can be re-applied to new 19-bit counts.

---
 rtl/sass_pkg.sv | 13 +
 rtl/seqmul_frac.sv | 95 +++++++++
 tb/tb_seqmul_frac.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sass_pkg.sv
// Shared constants and state encoding for the sequential fractional divider/multiplier pair.
package sass_pkg;

  localparam int unsigned DW = 19;
  localparam int unsigned FW = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } seqmul_state_t;

endpackage

// File: rtl/seqmul_frac.sv
// Sequential fractional multiplier: product = frac*scale/2^FW via shift-add, one fraction bit per clock.
// Define SEQMUL_ROUND_EN to round half up instead of truncating the final result.
module seqmul_frac
  import sass_pkg::*;
#(
  parameter int unsigned DW = sass_pkg::DW,
  parameter int unsigned FW = sass_pkg::FW
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          sample,
  input  logic [FW-1:0] frac,
  input  logic [DW-1:0] scale,
  output logic [DW-1:0] product,
  output logic          busy,
  output logic          done
);

  localparam int unsigned AW = DW + FW;
  localparam int unsigned CW = (FW > 1) ? $clog2(FW) : 1;

  seqmul_state_t   state;
  seqmul_state_t   state_nx;
  logic [FW-1:0]   frac_reg;
  logic [DW-1:0]   scale_reg;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   result;

`ifdef SEQMUL_ROUND_EN
  logic [AW:0]     acc_rnd;

  // acc + half-LSB cannot exceed (scale+1)*2^FW - 1, so the shifted value fits DW bits.
  always_comb begin
    acc_rnd = {1'b0, acc} + (AW+1)'(2**(FW-1));
    result  = DW'(acc_rnd >> FW);
  end
`else
  always_comb begin
    result = DW'(acc >> FW);
  end
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE) || done;
    case (state)
      IDLE:    if (sample) state_nx = RUN;
      RUN:     if (cnt == CW'(FW-1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      frac_reg  <= '0;
      scale_reg <= '0;
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sample) begin
            frac_reg  <= frac;
            scale_reg <= scale;
            acc       <= '0;
            cnt       <= '0;
          end
        end
        RUN: begin
          if (frac_reg[cnt]) acc <= acc + (AW'(scale_reg) << cnt);
          cnt <= cnt + CW'(1);
        end
        FINISH: begin
          product <= result;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seqmul_frac.sv
// Self-checking bench for seqmul_frac: cycle-level behavioural model plus directed literal checks.
module tb_seqmul_frac;

  localparam int unsigned DW = 19;
  localparam int unsigned FW = 8;

  logic          tb_clk = 1'b0;
  logic          RST    = 1'b0;
  logic          sample = 1'b0;
  logic [FW-1:0] frac   = '0;
  logic [DW-1:0] scale  = '0;
  logic [DW-1:0] product;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  seqmul_frac #(.DW(DW), .FW(FW)) dut (
    .clk(tb_clk), .RST(RST), .sample(sample), .frac(frac), .scale(scale),
    .product(product), .busy(busy), .done(done)
  );

  always #5 tb_clk = ~tb_clk;

  function automatic longint unsigned model_calc(input longint unsigned f, input longint unsigned s);
`ifdef SEQMUL_ROUND_EN
    return (f * s + 128) / 256;
`else
    return (f * s) / 256;
`endif
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: an accepted request keeps the block busy for FW+2 cycles; the last one is the done cycle.
  int              m_left = 0;
  longint unsigned m_pend = 0;
  longint unsigned m_prod = 0;

  always @(posedge tb_clk or posedge RST) begin
    if (RST) begin
      m_left = 0;
      m_prod = 0;
    end else if (m_left <= 1 && sample) begin
      m_left = FW + 2;
      m_pend = model_calc(frac, scale);
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 1) m_prod = m_pend;
    end
  end

  always @(negedge tb_clk) begin
    check("busy", busy, (m_left > 0) ? 1 : 0);
    check("done", done, (m_left == 1) ? 1 : 0);
    check("product", product, m_prod);
  end

  task automatic start(input int f, input int s);
    @(negedge tb_clk);
    sample = 1'b1;
    frac   = FW'(f);
    scale  = DW'(s);
    @(posedge tb_clk);
    #1;
    sample = 1'b0;
    frac   = FW'($urandom);
    scale  = DW'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge tb_clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic op(input string name, input int f, input int s, input int exp);
    int n;
    start(f, s);
    wait_done(n);
    check({name, "_latency"}, n, 9);
    check({name, "_product"}, product, exp);
  endtask

  initial begin
    int n;
    #1 RST = 1'b1;
    repeat (2) @(posedge tb_clk);
    #1;
    check("reset_product", product, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge tb_clk);
    RST = 1'b0;

`ifdef SEQMUL_ROUND_EN
    op("f229", 229, 152890, 136765);
    op("f128s3", 128, 3, 2);
`else
    op("f229", 229, 152890, 136764);
    op("f128s3", 128, 3, 1);
`endif
    op("f31", 31, 302791, 36666);
    op("f255max", 255, 524287, 522239);
    op("f0", 0, 524287, 0);
    op("s0", 200, 0, 0);

    // request during busy must be dropped
    start(229, 152890);
    repeat (3) @(negedge tb_clk);
    sample = 1'b1;
    frac   = 8'd1;
    scale  = 19'd7;
    @(posedge tb_clk);
    #1 sample = 1'b0;
    wait_done(n);
    check("ignore_latency", n, 6);
`ifdef SEQMUL_ROUND_EN
    check("ignore_product", product, 136765);
`else
    check("ignore_product", product, 136764);
`endif
    repeat (3) @(posedge tb_clk);
    #1 check("ignore_no_second_done", done, 0);

    // asynchronous reset mid-operation
    start(31, 302791);
    repeat (4) @(posedge tb_clk);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_product", product, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    @(negedge tb_clk);
    RST = 1'b0;
    repeat (12) @(posedge tb_clk);
    #1 check("rst_no_done", done, 0);
    op("after_rst", 31, 302791, 36666);

    // sample held high: back-to-back operations
    @(negedge tb_clk);
    sample = 1'b1;
    frac   = 8'd3;
    scale  = 19'd1000;
    repeat (30) @(negedge tb_clk);
    sample = 1'b0;
    repeat (12) @(negedge tb_clk);
    check("hold_product", product, model_calc(3, 1000));

    // randomized traffic, checked cycle by cycle by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge tb_clk);
      sample = ($urandom_range(0, 3) == 0);
      frac   = FW'($urandom);
      case ($urandom_range(0, 3))
        0:       scale = '0;
        1:       scale = '1;
        default: scale = DW'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) frac = ($urandom_range(0, 1) == 0) ? '0 : '1;
    end
    sample = 1'b0;
    repeat (15) @(negedge tb_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
